// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the default
// bit period agreed with the encoder-count transmitter.
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } state_e;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Resets to RESET_VAL so an idle-high line never looks like a falling edge.
module rx_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_count_receiver.sv
// UART receiver rebuilding the 8-bit Count sample; mid-bit sampling, 8N1 by default.
// Define UART_RX_PARITY_EN for 8E1 frames with an even-parity check and Parity_Err strobe.
module uart_count_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] Data,
  output logic                 Valid,
  output logic                 Frame_Err,
  output logic                 Parity_Err,
  output logic                 Busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int IDX_W    = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  rx_sync #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(CLK),
    .rst(RST),
    .d  (RX),
    .q  (rx_s)
  );

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 busy_q, busy_d;
  logic                 bit_done;
  logic                 par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  assign par_bad = par_bad_q;
`else
  assign par_bad = 1'b0;
`endif

  assign bit_done = (cnt_q == BIT_TC);

  // Start is re-checked at half a bit; every later sample lands a whole bit on, i.e. mid-bit.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    data_d       = data_q;
    valid_d      = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          cnt_d     = '0;
          par_bad_d = (^shift_q) ^ rx_s;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      // Leaving at mid-stop gives half a bit of slack to catch a back-to-back start edge.
      STOP: begin
        if (bit_done) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (par_bad) begin
              parity_err_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
          end else begin
            state_d      = WAIT_IDLE;
            frame_err_d  = 1'b1;
            parity_err_d = par_bad;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      busy_q       <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
`endif
    end
  end

  assign Data       = data_q;
  assign Valid      = valid_q;
  assign Frame_Err  = frame_err_q;
  assign Parity_Err = parity_err_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_uart_count_receiver.sv
// Bench for uart_count_receiver at 16 clocks per bit: a frame-level model predicts
// each strobe's cycle and the held byte; a compare process checks every cycle.
module tb_uart_count_receiver;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // Stop-bit sample point: 2 sync cycles, half a bit, whole bits to mid-stop, one output register.
  localparam int EVENT_LAT = 2 + HALF + (FRAME_BITS - 1) * CPB + 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX  = 1'b1;
  logic [7:0] Data;
  logic       Valid;
  logic       Frame_Err;
  logic       Parity_Err;
  logic       Busy;

  uart_count_receiver #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX        (RX),
    .Data      (Data),
    .Valid     (Valid),
    .Frame_Err (Frame_Err),
    .Parity_Err(Parity_Err),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       v;
    logic       fe;
    logic       pe;
    logic [7:0] d;
  } ev_t;

  ev_t        expQ[$];
  logic [7:0] mdlData = 8'h00;
  logic       expV, expFe, expPe;
  logic       sawValid = 1'b0;
  int         checks = 0;
  int         errors = 0;
  int         validSeen = 0;
  int         ferrSeen = 0;
  int         perrSeen = 0;
  int         lastValidCyc = 0;
  int         prevValidCyc = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic evenParity(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic driveLevel(input logic v, input int n);
    repeat (n) begin
      @(negedge CLK);
      RX = v;
    end
  endtask

  // One whole frame; the model decides the outcome purely from the bits being sent.
  task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input logic parBit);
    ev_t  e;
    logic parOk;
`ifdef UART_RX_PARITY_EN
    parOk = ((^d) ^ parBit) == 1'b0;
`else
    parOk = 1'b1;
`endif
    @(negedge CLK);
    RX   = 1'b0;
    e.at = cyc + EVENT_LAT;
    e.v  = stopBit && parOk;
    e.fe = !stopBit;
    e.pe = !parOk;
    e.d  = d;
    expQ.push_back(e);
    repeat (CPB - 1) @(negedge CLK);
    for (int i = 0; i < 8; i++) driveLevel(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    driveLevel(parBit, CPB);
`endif
    driveLevel(stopBit, CPB);
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      expQ.delete();
      mdlData  = 8'h00;
      sawValid = 1'b0;
      checkOutput("reset Data", {24'h0, Data}, 32'h0);
      checkOutput("reset Valid", {31'h0, Valid}, 32'h0);
      checkOutput("reset Frame_Err", {31'h0, Frame_Err}, 32'h0);
      checkOutput("reset Parity_Err", {31'h0, Parity_Err}, 32'h0);
      checkOutput("reset Busy", {31'h0, Busy}, 32'h0);
    end else begin
      expV  = 1'b0;
      expFe = 1'b0;
      expPe = 1'b0;
      if (expQ.size() > 0 && expQ[0].at == cyc) begin
        expV  = expQ[0].v;
        expFe = expQ[0].fe;
        expPe = expQ[0].pe;
        if (expQ[0].v) mdlData = expQ[0].d;
        void'(expQ.pop_front());
      end
      checkOutput("Valid", {31'h0, Valid}, {31'h0, expV});
      checkOutput("Frame_Err", {31'h0, Frame_Err}, {31'h0, expFe});
      checkOutput("Parity_Err", {31'h0, Parity_Err}, {31'h0, expPe});
      checkOutput("Data", {24'h0, Data}, {24'h0, mdlData});
      if (sawValid) checkOutput("Busy after Valid", {31'h0, Busy}, 32'h0);
      sawValid = expV;
      if (Valid) begin
        validSeen++;
        prevValidCyc = lastValidCyc;
        lastValidCyc = cyc;
      end
      if (Frame_Err) ferrSeen++;
      if (Parity_Err) perrSeen++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] rd;
    int         kind;

    RST = 1'b1;
    RX  = 1'b1;
    repeat (3) @(posedge CLK);
    @(posedge CLK) #2 RST = 1'b0;
    driveLevel(1'b1, 4);
    checkOutput("Busy idle after reset", {31'h0, Busy}, 32'h0);

    $display("[TB] 0xA5 single frame");
    applyStimulus(8'hA5, 1'b1, 1'b0);
    driveLevel(1'b1, 20);
    checkOutput("Data after A5", {24'h0, Data}, 32'hA5);
    checkOutput("Valid pulses after A5", validSeen, 1);
    checkOutput("Frame_Err pulses after A5", ferrSeen, 0);

    $display("[TB] short glitch");
    driveLevel(1'b0, 4);
    driveLevel(1'b1, 30);
    checkOutput("Busy after glitch", {31'h0, Busy}, 32'h0);
    checkOutput("Data held after glitch", {24'h0, Data}, 32'hA5);
    checkOutput("Valid pulses after glitch", validSeen, 1);

    $display("[TB] framing error then held break");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    driveLevel(1'b0, 40);
    driveLevel(1'b1, 20);
    checkOutput("Frame_Err pulses after break", ferrSeen, 1);
    checkOutput("Data held after framing error", {24'h0, Data}, 32'hA5);
    checkOutput("Valid pulses after break", validSeen, 1);
    applyStimulus(8'h01, 1'b1, 1'b1);
    driveLevel(1'b1, 20);
    checkOutput("Data after 01", {24'h0, Data}, 32'h01);

    $display("[TB] back-to-back 0x00 0xFF");
    applyStimulus(8'h00, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    driveLevel(1'b1, 20);
    checkOutput("Data after FF", {24'h0, Data}, 32'hFF);
    checkOutput("back-to-back Valid spacing", lastValidCyc - prevValidCyc, FRAME_BITS * CPB);

    $display("[TB] reset during data bit 4");
    b = 8'h77;
    driveLevel(1'b0, CPB);
    for (int i = 0; i < 4; i++) driveLevel(b[i], CPB);
    driveLevel(b[4], CPB / 2);
    @(posedge CLK) #2 RST = 1'b1;
    #1;
    checkOutput("mid-frame reset Data", {24'h0, Data}, 32'h0);
    checkOutput("mid-frame reset Busy", {31'h0, Busy}, 32'h0);
    checkOutput("mid-frame reset Valid", {31'h0, Valid}, 32'h0);
    RX = 1'b1;
    repeat (3) @(posedge CLK);
    @(posedge CLK) #2 RST = 1'b0;
    driveLevel(1'b1, 4);
    applyStimulus(8'h5A, 1'b1, 1'b0);
    driveLevel(1'b1, 20);
    checkOutput("Data after 5A", {24'h0, Data}, 32'h5A);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity frames");
    applyStimulus(8'h07, 1'b1, 1'b1);
    driveLevel(1'b1, 20);
    checkOutput("Data after 07 good parity", {24'h0, Data}, 32'h07);
    applyStimulus(8'h07, 1'b1, 1'b0);
    driveLevel(1'b1, 20);
    checkOutput("Parity_Err pulses", perrSeen, 1);
    checkOutput("Data held after parity error", {24'h0, Data}, 32'h07);
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 24; n++) begin
      rd   = 8'($urandom);
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        driveLevel(1'b0, int'($urandom_range(1, HALF - 1)));
        driveLevel(1'b1, CPB);
      end
`ifdef UART_RX_PARITY_EN
      applyStimulus(rd, kind != 1, evenParity(rd) ^ (kind == 2));
`else
      applyStimulus(rd, kind != 1, evenParity(rd));
`endif
      if (kind == 1) begin
        driveLevel(1'b0, int'($urandom_range(0, 30)));
        driveLevel(1'b1, int'($urandom_range(2, 10)));
      end else begin
        driveLevel(1'b1, int'($urandom_range(0, 8)));
      end
    end

    driveLevel(1'b1, 200);
    checkOutput("all predicted events seen", expQ.size(), 0);
    checkOutput("Parity_Err never without parity", perrSeen,
`ifdef UART_RX_PARITY_EN
                perrSeen);
`else
                0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
